// File: rtl/debouncer.sv
// debouncer: per-bit input filter with registered level, rise/fall pulses and an
// optional long-press pulse enabled by the DEBOUNCER_LONG_PRESS_EN macro.
`default_nettype none

module debouncer #(
  parameter int                 p_WIDTH         = 1,
  parameter int                 p_STABLE_CYCLES = 1000,
  parameter logic [p_WIDTH-1:0] p_INIT_VALUE    = '0,
  parameter int                 p_LONG_CYCLES   = 50000
) (
  input  logic               iw_clk,
  input  logic               iw_rst,
  input  logic [p_WIDTH-1:0] iwv_input,
  output logic [p_WIDTH-1:0] owv_state,
  output logic [p_WIDTH-1:0] owv_rise,
  output logic [p_WIDTH-1:0] owv_fall,
  output logic [p_WIDTH-1:0] owv_long
);

  localparam int            CW    = $clog2(p_STABLE_CYCLES + 1);
  localparam logic [CW-1:0] C_MAX = CW'(p_STABLE_CYCLES - 1);

  if (p_STABLE_CYCLES < 1 || p_LONG_CYCLES < 1) begin : g_bad_params
    $error("debouncer: p_STABLE_CYCLES and p_LONG_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < p_WIDTH; i++) begin : g_ch
    logic          s_q;
    logic [CW-1:0] c_q;
    logic          rise_q;
    logic          fall_q;
    logic          differ;
    logic          accept;

    assign differ = iwv_input[i] ^ s_q;
    // The counter only reaches C_MAX through consecutive differing samples.
    assign accept = differ && (c_q == C_MAX);

    always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
        s_q    <= p_INIT_VALUE[i];
        c_q    <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= accept & iwv_input[i];
        fall_q <= accept & ~iwv_input[i];
        if (!differ) begin
          c_q <= '0;
        end else if (accept) begin
          s_q <= iwv_input[i];
          c_q <= '0;
        end else begin
          c_q <= c_q + CW'(1);
        end
      end
    end

    assign owv_state[i] = s_q;
    assign owv_rise[i]  = rise_q;
    assign owv_fall[i]  = fall_q;

`ifdef DEBOUNCER_LONG_PRESS_EN
    localparam int            HW    = $clog2(p_LONG_CYCLES + 1);
    localparam logic [HW-1:0] H_MAX = HW'(p_LONG_CYCLES);
    localparam logic [HW-1:0] H_PRE = HW'(p_LONG_CYCLES - 1);

    logic [HW-1:0] h_q;
    logic          long_q;

    // Any accepted transition restarts the hold count; it saturates at H_MAX
    // so the pulse fires once per press.
    always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
        h_q    <= '0;
        long_q <= 1'b0;
      end else begin
        long_q <= 1'b0;
        if (accept) begin
          h_q <= '0;
        end else if (s_q && (h_q != H_MAX)) begin
          h_q    <= h_q + HW'(1);
          long_q <= (h_q == H_PRE);
        end
      end
    end

    assign owv_long[i] = long_q;
`else
    assign owv_long[i] = 1'b0;
`endif
  end

endmodule

`default_nettype wire
